axi_mem_rd_responder: RTL and testbench

- AXI4 slave read-channel responder (AR/R) backed by an internal word-addressed memory.
- Serves as the memory end of the DMA's MM2S read master, so the DMA read path can be exercised against synthesizable RTL rather than a pure UVM model.
- Bench preloads contents through a simple backdoor write port.
- Handles one outstanding burst at a time; INCR and FIXED bursts are supported.

---
 rtl/axi_mem_rd_responder_pkg.sv | 20 ++
 rtl/axi_rd_addr_gen.sv | 33 +++
 rtl/axi_mem_rd_responder.sv | 159 +++++++++++++++
 tb/tb_axi_mem_rd_responder.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/axi_mem_rd_responder_pkg.sv
// Shared AXI parameters and encodings for the memory-backed read responder.
package axi_mem_rd_responder_pkg;
  localparam int ADDR_WIDTH = 32;
  localparam int DATA_WIDTH = 32;
  localparam int Byte_Lanes = DATA_WIDTH / 8;
  localparam int FULL_SIZE  = $clog2(Byte_Lanes);

  typedef enum logic [1:0] {
    FIXED = 2'b00,
    INCR  = 2'b01,
    WRAP  = 2'b10
  } burst_t;

  typedef enum logic [1:0] {
    OKAY   = 2'b00,
    EXOKAY = 2'b01,
    SLVERR = 2'b10,
    DECERR = 2'b11
  } resp_t;
endpackage

// File: rtl/axi_rd_addr_gen.sv
// Beat address, memory word index and per-beat error flag for one read beat.
module axi_rd_addr_gen #(
  parameter int                    ADDR_WIDTH = 32,
  parameter int                    DATA_WIDTH = 32,
  parameter int                    MEM_DEPTH  = 1024,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = '0
) (
  input  logic [ADDR_WIDTH-1:0]        start_addr,
  input  logic [7:0]                   beat,
  input  logic [2:0]                   size,
  input  logic [1:0]                   burst,
  output logic [ADDR_WIDTH-1:0]        beat_addr,
  output logic                         in_range,
  output logic [$clog2(MEM_DEPTH)-1:0] word_idx,
  output logic                         err
);
  import axi_mem_rd_responder_pkg::*;

  localparam int LSB   = $clog2(DATA_WIDTH / 8);
  localparam int IDX_W = $clog2(MEM_DEPTH);

  logic [ADDR_WIDTH-1:0] word_off;

  // start_addr is already lane-aligned; FIXED and illegal bursts reuse it.
  always_comb begin
    beat_addr = start_addr;
    if (burst == INCR) beat_addr = start_addr + (ADDR_WIDTH'(beat) << LSB);
    word_off = (beat_addr - BASE_ADDR) >> LSB;
    in_range = (beat_addr >= BASE_ADDR) && (word_off < ADDR_WIDTH'(MEM_DEPTH));
    word_idx = word_off[IDX_W-1:0];
    err      = !in_range || (size != 3'(LSB)) || !((burst == FIXED) || (burst == INCR));
  end
endmodule

// File: rtl/axi_mem_rd_responder.sv
// AXI4 read-only slave (AR/R) returning bursts from an internal word memory
// that is preloaded through a byte-strobed backdoor write port.
module axi_mem_rd_responder #(
  parameter int                    ADDR_WIDTH = axi_mem_rd_responder_pkg::ADDR_WIDTH,
  parameter int                    DATA_WIDTH = axi_mem_rd_responder_pkg::DATA_WIDTH,
  parameter int                    ID_WIDTH   = 4,
  parameter int                    MEM_DEPTH  = 1024,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = '0
) (
  input  logic                    axi_aclk,
  input  logic                    axi_resetn,
  input  logic [ID_WIDTH-1:0]     s_axi_arid,
  input  logic [ADDR_WIDTH-1:0]   s_axi_araddr,
  input  logic [7:0]              s_axi_arlen,
  input  logic [2:0]              s_axi_arsize,
  input  logic [1:0]              s_axi_arburst,
  input  logic                    s_axi_arvalid,
  output logic                    s_axi_arready,
  output logic [ID_WIDTH-1:0]     s_axi_rid,
  output logic [DATA_WIDTH-1:0]   s_axi_rdata,
  output logic [1:0]              s_axi_rresp,
  output logic                    s_axi_rlast,
  output logic                    s_axi_rvalid,
  input  logic                    s_axi_rready,
  input  logic                    mem_wr_en,
  input  logic [ADDR_WIDTH-1:0]   mem_wr_addr,
  input  logic [DATA_WIDTH-1:0]   mem_wr_data,
  input  logic [DATA_WIDTH/8-1:0] mem_wr_strb
);
  import axi_mem_rd_responder_pkg::*;

  localparam int LANES = DATA_WIDTH / 8;
  localparam int LSB   = $clog2(LANES);
  localparam int IDX_W = $clog2(MEM_DEPTH);
  localparam logic [ADDR_WIDTH-1:0] ALIGN_MASK = ~ADDR_WIDTH'(LANES - 1);

  localparam logic [0:0] S_IDLE  = 1'b0;
  localparam logic [0:0] S_BURST = 1'b1;

  logic [0:0]            state;
  logic [ADDR_WIDTH-1:0] start_q;
  logic [7:0]            len_q;
  logic [7:0]            cnt_q;
  logic [2:0]            size_q;
  logic [1:0]            burst_q;

  logic [DATA_WIDTH-1:0] mem [MEM_DEPTH];

  logic                  idle;
  logic                  ar_fire;
  logic                  r_fire;
  logic [ADDR_WIDTH-1:0] gen_start;
  logic [7:0]            gen_beat;
  logic [2:0]            gen_size;
  logic [1:0]            gen_burst;
  logic [ADDR_WIDTH-1:0] gen_addr;
  logic                  gen_in_range;
  logic [IDX_W-1:0]      gen_idx;
  logic                  gen_err;

  // Handshakes: a transfer happens on the edge where valid and ready are both
  // high; R payload is held while rvalid is high and rready is low.
  assign idle    = (state == S_IDLE);
  assign ar_fire = s_axi_arvalid && s_axi_arready;
  assign r_fire  = s_axi_rvalid && s_axi_rready;

  // The generator always describes the beat that the next edge will load:
  // beat 0 of the incoming request in IDLE, the following beat in BURST.
  assign gen_start = idle ? (s_axi_araddr & ALIGN_MASK) : start_q;
  assign gen_beat  = idle ? 8'd0 : cnt_q + 8'd1;
  assign gen_size  = idle ? s_axi_arsize : size_q;
  assign gen_burst = idle ? s_axi_arburst : burst_q;

  axi_rd_addr_gen #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .DATA_WIDTH (DATA_WIDTH),
    .MEM_DEPTH  (MEM_DEPTH),
    .BASE_ADDR  (BASE_ADDR)
  ) u_addr_gen (
    .start_addr (gen_start),
    .beat       (gen_beat),
    .size       (gen_size),
    .burst      (gen_burst),
    .beat_addr  (gen_addr),
    .in_range   (gen_in_range),
    .word_idx   (gen_idx),
    .err        (gen_err)
  );

  always_ff @(posedge axi_aclk or negedge axi_resetn) begin
    if (!axi_resetn) begin
      state         <= S_IDLE;
      s_axi_arready <= 1'b0;
      s_axi_rvalid  <= 1'b0;
      s_axi_rlast   <= 1'b0;
      s_axi_rid     <= '0;
      s_axi_rdata   <= '0;
      s_axi_rresp   <= '0;
      start_q       <= '0;
      len_q         <= '0;
      cnt_q         <= '0;
      size_q        <= '0;
      burst_q       <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (ar_fire) begin
            state         <= S_BURST;
            s_axi_arready <= 1'b0;
            s_axi_rvalid  <= 1'b1;
            s_axi_rlast   <= (s_axi_arlen == 8'd0);
            s_axi_rid     <= s_axi_arid;
            s_axi_rdata   <= gen_err ? '0 : mem[gen_idx];
            s_axi_rresp   <= gen_err ? SLVERR : OKAY;
            start_q       <= gen_start;
            len_q         <= s_axi_arlen;
            cnt_q         <= 8'd0;
            size_q        <= s_axi_arsize;
            burst_q       <= s_axi_arburst;
          end else begin
            s_axi_arready <= 1'b1;
          end
        end
        default: begin
          if (r_fire) begin
            if (s_axi_rlast) begin
              state         <= S_IDLE;
              s_axi_rvalid  <= 1'b0;
              s_axi_rlast   <= 1'b0;
              s_axi_arready <= 1'b1;
            end else begin
              cnt_q       <= gen_beat;
              s_axi_rlast <= (gen_beat == len_q);
              s_axi_rdata <= gen_err ? '0 : mem[gen_idx];
              s_axi_rresp <= gen_err ? SLVERR : OKAY;
            end
          end
        end
      endcase
    end
  end

  // Backdoor write; a same-edge fetch of this word still sees the old value.
  logic [ADDR_WIDTH-1:0] wr_off;
  logic                  wr_ok;
  assign wr_off = (mem_wr_addr - BASE_ADDR) >> LSB;
  assign wr_ok  = (mem_wr_addr >= BASE_ADDR) && (wr_off < ADDR_WIDTH'(MEM_DEPTH));

  always_ff @(posedge axi_aclk) begin
    if (mem_wr_en && wr_ok) begin
      for (int b = 0; b < LANES; b++) begin
        if (mem_wr_strb[b]) mem[wr_off[IDX_W-1:0]][b*8 +: 8] <= mem_wr_data[b*8 +: 8];
      end
    end
  end

  logic unused_ok;
  assign unused_ok = &{1'b0, gen_addr, gen_in_range};
endmodule

// File: tb/tb_axi_mem_rd_responder.sv
// Directed bench for axi_mem_rd_responder: burst vector table plus reset,
// collision and backpressure sequences.
module tb_axi_mem_rd_responder;
  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic [3:0]  arid = '0;
  logic [31:0] araddr = '0;
  logic [7:0]  arlen = '0;
  logic [2:0]  arsize = '0;
  logic [1:0]  arburst = '0;
  logic        arvalid = 1'b0;
  logic        arready;
  logic [3:0]  rid;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rlast;
  logic        rvalid;
  logic        rready = 1'b0;
  logic        wr_en = 1'b0;
  logic [31:0] wr_addr = '0;
  logic [31:0] wr_data = '0;
  logic [3:0]  wr_strb = '0;

  int n_checks = 0;
  int n_fail   = 0;
  logic [31:0] exp_q[$];

  typedef struct {
    logic [3:0]  id;
    logic [31:0] addr;
    logic [7:0]  len;
    logic [2:0]  size;
    logic [1:0]  burst;
    logic [15:0] pat;
    logic [31:0] data [4];
    logic [3:0]  err;
    logic        coll;
    logic [31:0] coll_data;
  } vec_t;

  vec_t vecs [11];

  axi_mem_rd_responder dut (
    .axi_aclk      (clk),
    .axi_resetn    (rst_n),
    .s_axi_arid    (arid),
    .s_axi_araddr  (araddr),
    .s_axi_arlen   (arlen),
    .s_axi_arsize  (arsize),
    .s_axi_arburst (arburst),
    .s_axi_arvalid (arvalid),
    .s_axi_arready (arready),
    .s_axi_rid     (rid),
    .s_axi_rdata   (rdata),
    .s_axi_rresp   (rresp),
    .s_axi_rlast   (rlast),
    .s_axi_rvalid  (rvalid),
    .s_axi_rready  (rready),
    .mem_wr_en     (wr_en),
    .mem_wr_addr   (wr_addr),
    .mem_wr_data   (wr_data),
    .mem_wr_strb   (wr_strb)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic set_vec(input int i, input logic [3:0] id, input logic [31:0] addr,
                         input logic [7:0] len, input logic [2:0] size, input logic [1:0] burst,
                         input logic [15:0] pat, input logic [31:0] d0, input logic [31:0] d1,
                         input logic [31:0] d2, input logic [31:0] d3, input logic [3:0] err,
                         input logic coll, input logic [31:0] coll_data);
    vecs[i].id = id;     vecs[i].addr = addr;   vecs[i].len = len;
    vecs[i].size = size; vecs[i].burst = burst; vecs[i].pat = pat;
    vecs[i].data[0] = d0; vecs[i].data[1] = d1;
    vecs[i].data[2] = d2; vecs[i].data[3] = d3;
    vecs[i].err = err; vecs[i].coll = coll; vecs[i].coll_data = coll_data;
  endtask

  task automatic bd_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
    wr_en = 1'b1; wr_addr = a; wr_data = d; wr_strb = s;
    @(posedge clk); #1;
    wr_en = 1'b0;
  endtask

  // Issue one AR and consume the whole burst, checking every cycle rvalid is high.
  task automatic run_vec(input int v);
    vec_t t;
    int w;
    int beat;
    int cyc;
    t = vecs[v];
    exp_q.delete();
    for (int b = 0; b <= int'(t.len); b++) exp_q.push_back(t.data[b]);
    arid = t.id; araddr = t.addr; arlen = t.len; arsize = t.size; arburst = t.burst;
    arvalid = 1'b1;
    w = 0;
    while (!arready && w < 20) begin
      @(posedge clk); #1;
      w++;
    end
    if (w == 20) check($sformatf("v%0d_arready_timeout", v), 32'(arready), 32'd1);
    if (t.coll) begin
      wr_en = 1'b1; wr_addr = t.addr & 32'hFFFF_FFFC; wr_data = t.coll_data; wr_strb = 4'hF;
    end
    @(posedge clk); #1;
    arvalid = 1'b0;
    wr_en = 1'b0;
    check($sformatf("v%0d_ar_to_r_valid", v), 32'(rvalid), 32'd1);
    beat = 0;
    cyc = 0;
    while (beat <= int'(t.len) && cyc < 100) begin
      check($sformatf("v%0d_rvalid", v), 32'(rvalid), 32'd1);
      check($sformatf("v%0d_arready_busy", v), 32'(arready), 32'd0);
      if (rvalid && exp_q.size() > 0) begin
        check($sformatf("v%0d_b%0d_rdata", v, beat), rdata, exp_q[0]);
        check($sformatf("v%0d_b%0d_rresp", v, beat), 32'(rresp), t.err[beat] ? 32'd2 : 32'd0);
        check($sformatf("v%0d_b%0d_rid", v, beat), 32'(rid), 32'(t.id));
        check($sformatf("v%0d_b%0d_rlast", v, beat), 32'(rlast), (beat == int'(t.len)) ? 32'd1 : 32'd0);
      end
      rready = t.pat[cyc % 16];
      if (rvalid && rready) begin
        void'(exp_q.pop_front());
        beat++;
      end
      @(posedge clk); #1;
      cyc++;
    end
    if (cyc == 100) check($sformatf("v%0d_burst_timeout", v), 32'(cyc), 32'd0);
    rready = 1'b0;
    check($sformatf("v%0d_end_rvalid", v), 32'(rvalid), 32'd0);
    check($sformatf("v%0d_end_rlast", v), 32'(rlast), 32'd0);
    check($sformatf("v%0d_end_arready", v), 32'(arready), 32'd1);
  endtask

  initial begin
    // id, addr, len, size, burst, rready pattern, data beats 0..3, SLVERR mask, collision
    set_vec(0,  4'h3, 32'h000, 8'd3, 3'd2, 2'b01, 16'hFFFF,
            32'hA000_0000, 32'hA000_0001, 32'hA000_0002, 32'hA000_0003, 4'b0000, 1'b0, 32'h0);
    set_vec(1,  4'h5, 32'h008, 8'd2, 3'd2, 2'b00, 16'hFFFF,
            32'hA000_0002, 32'hA000_0002, 32'hA000_0002, 32'h0, 4'b0000, 1'b0, 32'h0);
    set_vec(2,  4'h1, 32'hFF8, 8'd3, 3'd2, 2'b01, 16'hFFFF,
            32'hB000_03FE, 32'hB000_03FF, 32'h0, 32'h0, 4'b1100, 1'b0, 32'h0);
    set_vec(3,  4'h7, 32'h000, 8'd1, 3'd1, 2'b01, 16'hFFFF,
            32'h0, 32'h0, 32'h0, 32'h0, 4'b0011, 1'b0, 32'h0);
    set_vec(4,  4'h2, 32'h004, 8'd1, 3'd2, 2'b10, 16'hFFFF,
            32'h0, 32'h0, 32'h0, 32'h0, 4'b0011, 1'b0, 32'h0);
    set_vec(5,  4'h9, 32'h006, 8'd1, 3'd2, 2'b01, 16'hFFFF,
            32'hA000_0001, 32'hA000_0002, 32'h0, 32'h0, 4'b0000, 1'b0, 32'h0);
    set_vec(6,  4'hF, 32'h03C, 8'd0, 3'd2, 2'b01, 16'hFFFF,
            32'hA000_000F, 32'h0, 32'h0, 32'h0, 4'b0000, 1'b0, 32'h0);
    set_vec(7,  4'h4, 32'h010, 8'd3, 3'd2, 2'b01, 16'h9999,
            32'hA000_0004, 32'hA000_0005, 32'hA000_0006, 32'hA000_0007, 4'b0000, 1'b0, 32'h0);
    set_vec(8,  4'h6, 32'h050, 8'd0, 3'd2, 2'b01, 16'hFFFF,
            32'h11BB_33DD, 32'h0, 32'h0, 32'h0, 4'b0000, 1'b0, 32'h0);
    set_vec(9,  4'hA, 32'h060, 8'd1, 3'd2, 2'b00, 16'hFFFF,
            32'hC000_0018, 32'h5555_5555, 32'h0, 32'h0, 4'b0000, 1'b1, 32'h5555_5555);
    set_vec(10, 4'h0, 32'h07C, 8'd1, 3'd2, 2'b11, 16'hFFFF,
            32'h0, 32'h0, 32'h0, 32'h0, 4'b0011, 1'b0, 32'h0);

    // Reset state
    #1 rst_n = 1'b0;
    #2;
    check("rst_arready", 32'(arready), 32'd0);
    check("rst_rvalid", 32'(rvalid), 32'd0);
    check("rst_rlast", 32'(rlast), 32'd0);
    check("rst_rid", 32'(rid), 32'd0);
    check("rst_rdata", rdata, 32'd0);
    check("rst_rresp", 32'(rresp), 32'd0);
    repeat (2) @(posedge clk);
    #1 check("rst_hold_arready", 32'(arready), 32'd0);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
    check("post_rst_arready", 32'(arready), 32'd1);

    // Preload
    for (int i = 0; i < 16; i++) bd_write(32'(i * 4), 32'hA000_0000 + 32'(i), 4'hF);
    bd_write(32'hFF8, 32'hB000_03FE, 4'hF);
    bd_write(32'hFFC, 32'hB000_03FF, 4'hF);
    bd_write(32'h050, 32'h1122_3344, 4'hF);
    bd_write(32'h050, 32'hAABB_CCDD, 4'b0101);
    bd_write(32'h060, 32'hC000_0018, 4'hF);
    bd_write(32'h1000, 32'hDEAD_BEEF, 4'hF);

    for (int v = 0; v < 11; v++) run_vec(v);

    // Reset in the middle of a burst, after beat 1 has been accepted
    arid = 4'h3; araddr = 32'h0; arlen = 8'd3; arsize = 3'd2; arburst = 2'b01;
    arvalid = 1'b1;
    @(posedge clk); #1;
    arvalid = 1'b0;
    rready = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    check("mid_pre_rdata", rdata, 32'hA000_0002);
    #2 rst_n = 1'b0;
    #1;
    check("mid_rst_rvalid", 32'(rvalid), 32'd0);
    check("mid_rst_rlast", 32'(rlast), 32'd0);
    check("mid_rst_rdata", rdata, 32'd0);
    check("mid_rst_rid", 32'(rid), 32'd0);
    check("mid_rst_arready", 32'(arready), 32'd0);
    rready = 1'b0;
    repeat (2) @(posedge clk);
    #1 check("mid_rst_hold_rvalid", 32'(rvalid), 32'd0);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
    check("mid_post_arready", 32'(arready), 32'd1);
    check("mid_post_rvalid", 32'(rvalid), 32'd0);
    run_vec(0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not complete, time %0t", $time);
    $fatal(1, "timeout");
  end
endmodule
